// File: rtl/cellram_responder_pkg.sv
// Shared types and constants for the cellular-RAM loopback responder.
// Holds the bus FSM encoding, counter width and data-bus width.
package cellram_responder_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DQ_W  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdDrive,
        StWrActive
    } state_e;

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cellram_responder_array.sv
// Single-port 2^ADDR_W x 16 storage with per-byte write enables.
// Read is asynchronous so the read latency lives entirely in the top-level FSM.
module cellram_responder_array
    import cellram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_lo,
    input  logic              we_hi,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DQ_W-1:0]   wdata,
    output logic [DQ_W-1:0]   rdata
);

    logic [DQ_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_lo) mem[addr][7:0]  <= wdata[7:0];
        if (we_hi) mem[addr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cellram_responder.sv
// Async cellular-RAM bus responder: FSM, latency/width counters, statistics and
// the MemDB tri-state, backed by an internal byte-writable array.
module cellram_responder
    import cellram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 3,
    parameter int unsigned WR_MIN   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [26:1]     MemAdr,
    inout  wire  [DQ_W-1:0] MemDB,
    input  logic            RamCS,
    input  logic            MemOE,
    input  logic            MemWR,
    input  logic            RamLB,
    input  logic            RamUB,
    input  logic            MemAdv,
    input  logic            MemClk,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count,
    output logic            proto_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DQ_W-1:0]   wdata_q, wdata_d;
    logic              wlb_q, wlb_d, wub_q, wub_d;
    logic [15:0]       rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic              perr_q, perr_d;
    logic              commit;
    logic [DQ_W-1:0]   rdata;

    logic [ADDR_W-1:0] bus_addr;
    logic              sel, addr_chg;
    logic              unused_adr;

    assign bus_addr   = MemAdr[ADDR_W:1];
    assign unused_adr = ^MemAdr[26:ADDR_W+1];
    assign sel        = !RamCS && !MemAdv;
    assign addr_chg   = bus_addr != addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        wlb_d      = wlb_q;
        wub_d      = wub_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        perr_d     = !RamCS && MemClk;
        commit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel && !MemWR) begin
                    state_d = StWrActive;
                    addr_d  = bus_addr;
                    cnt_d   = CNT_W'(1);
                    wdata_d = MemDB;
                    wlb_d   = RamLB;
                    wub_d   = RamUB;
                end else if (sel && !MemOE) begin
                    state_d = StRdWait;
                    addr_d  = bus_addr;
                    cnt_d   = CNT_W'(1);
                end
            end
            StRdWait: begin
                if (!sel || MemOE) begin
                    state_d = StIdle;
                end else if (!MemWR) begin
                    state_d = StWrActive;
                    addr_d  = bus_addr;
                    cnt_d   = CNT_W'(1);
                    wdata_d = MemDB;
                    wlb_d   = RamLB;
                    wub_d   = RamUB;
                end else if (addr_chg) begin
                    addr_d = bus_addr;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == CNT_W'(READ_LAT)) begin
                    state_d    = StRdDrive;
                    rd_count_d = rd_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRdDrive: begin
                if (!sel || MemOE || !MemWR) begin
                    state_d = StIdle;
                end else if (addr_chg) begin
                    state_d = StRdWait;
                    addr_d  = bus_addr;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWrActive: begin
                if (!sel || MemWR) begin
                    state_d = StIdle;
                    if (cnt_q >= CNT_W'(WR_MIN)) begin
                        commit     = 1'b1;
                        wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end else begin
                    // Address moved under an active write: restart the pulse-width count.
                    if (addr_chg) begin
                        perr_d = 1'b1;
                        addr_d = bus_addr;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                    wdata_d = MemDB;
                    wlb_d   = RamLB;
                    wub_d   = RamUB;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            wlb_q      <= 1'b1;
            wub_q      <= 1'b1;
            rd_count_q <= '0;
            wr_count_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            wlb_q      <= wlb_d;
            wub_q      <= wub_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            perr_q     <= perr_d;
        end
    end

    cellram_responder_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we_lo (commit && !wlb_q && !rst),
        .we_hi (commit && !wub_q && !rst),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign MemDB     = (state_q == StRdDrive) ? rdata : {DQ_W{1'bz}};
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_cellram_responder.sv
// Directed and randomized bench for cellram_responder against a word-array model.
// MemDB carries pull-ups, so a released bus reads as all ones.
module tb_cellram_responder;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned READ_LAT = 3;
    localparam int unsigned WR_MIN   = 2;
    localparam logic [15:0] HIZ      = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:1] MemAdr;
    logic        RamCS, MemOE, MemWR, RamLB, RamUB, MemAdv, MemClk;
    logic        tb_drv;
    logic [15:0] tb_dq;
    wire  [15:0] MemDB;
    logic [15:0] rd_count, wr_count;
    logic        proto_err;

    always #5 clk = ~clk;

    assign MemDB = tb_drv ? tb_dq : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (MemDB[i]);
    end

    cellram_responder #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT),
        .WR_MIN   (WR_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemAdr    (MemAdr),
        .MemDB     (MemDB),
        .RamCS     (RamCS),
        .MemOE     (MemOE),
        .MemWR     (MemWR),
        .RamLB     (RamLB),
        .RamUB     (RamUB),
        .MemAdv    (MemAdv),
        .MemClk    (MemClk),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .proto_err (proto_err)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mem_m [1024];
    int          exp_rd = 0;
    int          exp_wr = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        RamCS  = 1'b1;
        MemOE  = 1'b1;
        MemWR  = 1'b1;
        RamLB  = 1'b1;
        RamUB  = 1'b1;
        MemAdv = 1'b0;
        MemClk = 1'b0;
        tb_drv = 1'b0;
    endtask

    // Holds WR low for ncyc sampled edges, then releases; model commits on width.
    task automatic do_write(input logic [26:1] a, input logic [15:0] d, input logic lb,
                            input logic ub, input int ncyc, input logic oe);
        logic [ADDR_W-1:0] idx;
        idx    = a[ADDR_W:1];
        MemAdr = a;
        RamCS  = 1'b0;
        MemWR  = 1'b0;
        MemOE  = oe;
        RamLB  = lb;
        RamUB  = ub;
        tb_dq  = d;
        tb_drv = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (!oe) chk("wr_oe_low_bus", MemDB, d);
        end
        idle_bus();
        step();
        if (ncyc >= int'(WR_MIN)) begin
            if (!lb) mem_m[idx][7:0] = d[7:0];
            if (!ub) mem_m[idx][15:8] = d[15:8];
            exp_wr++;
        end
        chk("wr_proto_err", {15'd0, proto_err}, (ncyc < int'(WR_MIN)) ? 16'd1 : 16'd0);
        chk("wr_count", wr_count, exp_wr[15:0]);
        step();
        chk("wr_perr_pulse_end", {15'd0, proto_err}, 16'd0);
    endtask

    // Read with latency check; OE is raised in the drive state to check release.
    task automatic do_read(input logic [26:1] a, input logic clk_err, input string tag);
        logic [15:0] exp;
        exp    = mem_m[a[ADDR_W:1]];
        MemAdr = a;
        RamCS  = 1'b0;
        MemOE  = 1'b0;
        MemClk = clk_err;
        for (int i = 0; i < int'(READ_LAT); i++) begin
            step();
            chk({tag, "_lat_hiz"}, MemDB, HIZ);
            if (i == 0 && clk_err) begin
                chk("memclk_perr", {15'd0, proto_err}, 16'd1);
                MemClk = 1'b0;
            end
        end
        step();
        exp_rd++;
        chk(tag, MemDB, exp);
        chk("rd_count", rd_count, exp_rd[15:0]);
        MemOE = 1'b1;
        step();
        chk({tag, "_oe_release"}, MemDB, HIZ);
        idle_bus();
        step();
    endtask

    initial begin
        logic [ADDR_W-1:0] pool [8];
        logic [26:1]       a;
        logic [15:0]       d;

        idle_bus();
        rst    = 1'b1;
        MemAdr = '0;
        tb_dq  = '0;
        step();
        step();
        chk("rst_bus", MemDB, HIZ);
        chk("rst_rd_count", rd_count, 16'd0);
        chk("rst_wr_count", wr_count, 16'd0);
        chk("rst_proto_err", {15'd0, proto_err}, 16'd0);
        rst = 1'b0;
        step();

        do_write(26'd5, 16'h1234, 1'b0, 1'b0, 4, 1'b1);
        do_read(26'd5, 1'b0, "rd_1234");
        chk("rd_1234_const", mem_m[5], 16'h1234);

        do_write(26'd5, 16'hAB00, 1'b1, 1'b0, 3, 1'b1);
        do_read(26'd5, 1'b0, "rd_ub_only");

        do_write(26'd5, 16'hFFFF, 1'b0, 1'b0, 1, 1'b1);
        do_read(26'd5, 1'b0, "rd_after_short_wr");

        // OE held low through a write: the bus must only ever carry the writer's data.
        do_write(26'd9, 16'h5A5A, 1'b0, 1'b0, 3, 1'b0);
        do_read(26'd9, 1'b0, "rd_wr_with_oe");

        // Reset during the latency wait.
        MemAdr = 26'd5;
        RamCS  = 1'b0;
        MemOE  = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_in_rd_wait_bus", MemDB, HIZ);
        rst = 1'b0;
        idle_bus();
        exp_rd = 0;
        exp_wr = 0;
        step();

        // Reset while driving.
        MemAdr = 26'd5;
        RamCS  = 1'b0;
        MemOE  = 1'b0;
        repeat (READ_LAT + 1) step();
        chk("pre_rst_drive", MemDB, mem_m[5]);
        rst = 1'b1;
        step();
        chk("rst_in_rd_drive_bus", MemDB, HIZ);
        chk("rst_in_rd_drive_cnt", rd_count, 16'd0);
        rst = 1'b0;
        idle_bus();
        step();
        do_read(26'd5, 1'b0, "rd_after_rst");
        do_read(26'd5, 1'b1, "rd_memclk_high");

        // Randomized traffic over a small pool, addressed through random alias bits.
        for (int k = 0; k < 8; k++) begin
            pool[k] = ADDR_W'($urandom);
            d = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
            a = 26'($urandom);
            a[ADDR_W:1] = pool[k];
            do_write(a, d, 1'b0, 1'b0, 2, 1'b1);
        end
        for (int n = 0; n < 24; n++) begin
            a = 26'($urandom);
            a[ADDR_W:1] = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) begin
                d = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
                do_write(a, d, 1'($urandom), 1'($urandom), int'($urandom_range(1, 5)), 1'b1);
            end else begin
                do_read(a, 1'b0, "rd_rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
